// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU for the IL execute stage. Single-cycle logic,
// compare, add/sub (with carry chaining), shift and load operations, plus an
// iterative radix-2 shift-add multiplier. Valid/ready handshake on both sides.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    operation presented        in_ready   operation accepted this cycle
//   opcode      operation select           op1, op2   operands (WIDTH bits)
//   out_valid   result held                out_ready  consumer takes result
//   out_data    result (low half for MUL)  out_hi     MUL high half, else 0
//   carry_flag  persistent carry/borrow    zero_flag  out_data == 0 while out_valid
//   err         result from unknown opcode flag_clr   synchronous carry clear
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             err,
  input  logic             flag_clr
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_GT   = 4'd3;
  localparam logic [3:0] OP_GE   = 4'd4;
  localparam logic [3:0] OP_EQ   = 4'd5;
  localparam logic [3:0] OP_LE   = 4'd6;
  localparam logic [3:0] OP_LT   = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ADDC = 4'd11;
  localparam logic [3:0] OP_SUBB = 4'd12;
  localparam logic [3:0] OP_SHL  = 4'd13;
  localparam logic [3:0] OP_SHR  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  typedef enum logic {IDLE, MULT} state_t;

  state_t               state_q, state_d;
  logic                 vld_q, vld_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 carry_q, carry_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_last;
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   prod_nxt;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cout;
  logic                 alu_wc;
  logic                 alu_err;
  logic [WIDTH:0]       wide;
  logic [WIDTH:0]       ext_a, ext_b, ext_c;

  assign in_ready   = reset && (state_q == IDLE) && (!vld_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign mul_start  = accept && (opcode == OP_MUL) && (MUL_EN != 0);
  assign mul_last   = (state_q == MULT) && (cnt_q == CNT_W'(WIDTH - 1));

  // One shift-add step: the low half holds the remaining multiplier bits,
  // the high half accumulates; the whole product shifts right each cycle.
  assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_nxt = {step_sum, prod_q[WIDTH-1:1]};

  // Operands zero-extended by one bit so the carry/borrow survives in bit WIDTH.
  assign ext_a = {1'b0, op1};
  assign ext_b = {1'b0, op2};
  assign ext_c = {{WIDTH{1'b0}}, carry_q};

  always_comb begin
    alu_res  = '0;
    alu_cout = carry_q;
    alu_wc   = 1'b0;
    alu_err  = 1'b0;
    wide     = '0;
    case (opcode)
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_GT:   alu_res = WIDTH'(op1 >  op2);
      OP_GE:   alu_res = WIDTH'(op1 >= op2);
      OP_EQ:   alu_res = WIDTH'(op1 == op2);
      OP_LE:   alu_res = WIDTH'(op1 <= op2);
      OP_LT:   alu_res = WIDTH'(op1 <  op2);
      OP_LD:   alu_res = op1;
      OP_ADD, OP_ADDC: begin
        wide     = ext_a + ext_b + ((opcode == OP_ADDC) ? ext_c : '0);
        alu_res  = wide[WIDTH-1:0];
        alu_cout = wide[WIDTH];
        alu_wc   = 1'b1;
      end
      OP_SUB, OP_SUBB: begin
        wide     = ext_a - ext_b - ((opcode == OP_SUBB) ? ext_c : '0);
        alu_res  = wide[WIDTH-1:0];
        alu_cout = wide[WIDTH];
        alu_wc   = 1'b1;
      end
      OP_SHL: begin
        alu_res  = {op1[WIDTH-2:0], 1'b0};
        alu_cout = op1[WIDTH-1];
        alu_wc   = 1'b1;
      end
      OP_SHR: begin
        alu_res  = {1'b0, op1[WIDTH-1:1]};
        alu_cout = op1[0];
        alu_wc   = 1'b1;
      end
      default: begin
        // Only reachable for MUL with the multiplier disabled.
        alu_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    data_d  = data_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    err_d   = err_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;

    if (vld_q && out_ready) vld_d = 1'b0;
    // A carry-writing result load below overrides this clear.
    if (flag_clr) carry_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mul_start) begin
          state_d = MULT;
          mcand_d = op1;
          prod_d  = {{WIDTH{1'b0}}, op2};
          cnt_d   = '0;
        end else if (accept) begin
          vld_d  = 1'b1;
          data_d = alu_res;
          hi_d   = '0;
          err_d  = alu_err;
          if (alu_wc) carry_d = alu_cout;
        end
      end
      MULT: begin
        prod_d = prod_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (mul_last) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          data_d  = prod_nxt[WIDTH-1:0];
          hi_d    = prod_nxt[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
          carry_d = |prod_nxt[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      data_q  <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_data   = data_q;
  assign out_hi     = hi_q;
  assign carry_flag = carry_q;
  assign err        = err_q;
  assign zero_flag  = vld_q && (data_q == '0);

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid, in_valid2;
  logic         in_ready, in_ready2;
  logic [3:0]   opcode;
  logic [W-1:0] op1, op2;
  logic         out_valid, out_valid2;
  logic         out_ready;
  logic [W-1:0] out_data, out_data2, out_hi, out_hi2;
  logic         carry_flag, carry2, zero_flag, zero2, err, err2;
  logic         flag_clr;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op1(op1), .op2(op2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_hi(out_hi),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .err(err),
    .flag_clr(flag_clr)
  );

  alu_pipe #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .opcode(opcode), .op1(op1), .op2(op2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_hi(out_hi2),
    .carry_flag(carry2), .zero_flag(zero2), .err(err2),
    .flag_clr(flag_clr)
  );

  typedef struct {
    logic [7:0] d;
    logic [7:0] h;
    logic       c;
    logic       e;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic mc = 1'b0;
  bit   rnd_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
    exp_t r;
    int   s;
    int   ci;
    ci = cin ? 1 : 0;
    r.d = 8'h00; r.h = 8'h00; r.c = cin; r.e = 1'b0;
    s = 0;
    case (op)
      4'd0:  r.d = a & b;
      4'd1:  r.d = a | b;
      4'd2:  r.d = a ^ b;
      4'd3:  r.d = (a >  b) ? 8'd1 : 8'd0;
      4'd4:  r.d = (a >= b) ? 8'd1 : 8'd0;
      4'd5:  r.d = (a == b) ? 8'd1 : 8'd0;
      4'd6:  r.d = (a <= b) ? 8'd1 : 8'd0;
      4'd7:  r.d = (a <  b) ? 8'd1 : 8'd0;
      4'd8:  begin s = int'(a) + int'(b);      r.d = s[7:0]; r.c = s[8]; end
      4'd9:  begin s = int'(a) - int'(b);      r.d = s[7:0]; r.c = (s < 0); end
      4'd10: r.d = a;
      4'd11: begin s = int'(a) + int'(b) + ci; r.d = s[7:0]; r.c = s[8]; end
      4'd12: begin s = int'(a) - int'(b) - ci; r.d = s[7:0]; r.c = (s < 0); end
      4'd13: begin r.d = {a[6:0], 1'b0}; r.c = a[7]; end
      4'd14: begin r.d = {1'b0, a[7:1]}; r.c = a[0]; end
      default: begin
        s = int'(a) * int'(b);
        r.d = s[7:0]; r.h = s[15:8]; r.c = (s[15:8] != 8'h00);
      end
    endcase
    return r;
  endfunction

  // Scoreboard: compare every consumed result against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("stale_vld", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("data",  {24'd0, out_data}, {24'd0, e.d});
        chk("hi",    {24'd0, out_hi},   {24'd0, e.h});
        chk("carry", {31'd0, carry_flag}, {31'd0, e.c});
        chk("err",   {31'd0, err},       {31'd0, e.e});
        chk("zero",  {31'd0, zero_flag}, {31'd0, (e.d == 8'h00)});
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic clr = 1'b0);
    int   n;
    exp_t e;
    @(negedge clk);
    opcode = op; op1 = a; op2 = b; in_valid = 1'b1; flag_clr = clr;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("acc_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0; flag_clr = 1'b0;
      return;
    end
    e = model(op, a, b, mc);
    if (clr && !(op inside {4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15})) e.c = 1'b0;
    mc = e.c;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain", sbq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int viol;
    int seen;
    in_valid = 1'b0; in_valid2 = 1'b0; opcode = 4'd0; op1 = '0; op2 = '0;
    out_ready = 1'b1; flag_clr = 1'b0;

    #1 reset = 1'b0;
    #2;
    chk("rst_vld",   {31'd0, out_valid},  32'd0);
    chk("rst_rdy",   {31'd0, in_ready},   32'd0);
    chk("rst_data",  {24'd0, out_data},   32'd0);
    chk("rst_carry", {31'd0, carry_flag}, 32'd0);
    chk("rst_err",   {31'd0, err},        32'd0);
    chk("rst_zero",  {31'd0, zero_flag},  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk("rdy_after_rst", {31'd0, in_ready}, 32'd1);

    // carry chaining
    do_op(4'd8, 8'hF0, 8'h20);
    chk("add_carry", {31'd0, carry_flag}, 32'd1);
    do_op(4'd11, 8'h01, 8'h01);
    do_op(4'd9, 8'h05, 8'h06);
    do_op(4'd12, 8'h10, 8'h00);
    for (int k = 3; k <= 7; k++) do_op(4'(k), 8'h07, 8'h07);
    do_op(4'd1, 8'h50, 8'h0A);
    do_op(4'd10, 8'hC3, 8'h11);
    do_op(4'd13, 8'h81, 8'h00);
    do_op(4'd14, 8'h81, 8'h00);
    drain();

    // multiplier latency and stall
    do_op(4'd15, 8'hFF, 8'hFF);
    n = 1; viol = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) viol++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_lat", n, 32'd9);
    chk("mul_rdy", viol, 32'd0);
    drain();

    // back-to-back, then consumer stall
    do_op(4'd0, 8'hF0, 8'h3C);
    do_op(4'd2, 8'hAA, 8'hFF);
    chk("b2b_vld", {31'd0, out_valid}, 32'd1);
    chk("b2b_sb", sbq.size(), 32'd1);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold_rdy",  {31'd0, in_ready},  32'd0);
      chk("hold_data", {24'd0, out_data},  32'h55);
      chk("hold_zero", {31'd0, zero_flag}, 32'd0);
    end
    out_ready = 1'b1;
    do_op(4'd0, 8'h0F, 8'hF0);
    drain();

    // flag clear priority
    do_op(4'd8, 8'hF0, 8'h20, 1'b1);
    chk("clr_vs_add", {31'd0, carry_flag}, 32'd1);
    drain();
    @(negedge clk) flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    mc = 1'b0;
    chk("clr_only", {31'd0, carry_flag}, 32'd0);

    // multiplier disabled: opcode 15 is unknown
    @(negedge clk);
    opcode = 4'd15; op1 = 8'h03; op2 = 8'h05; in_valid2 = 1'b1;
    n = 0;
    while (!in_ready2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    chk("nomul_vld",  {31'd0, out_valid2}, 32'd1);
    chk("nomul_err",  {31'd0, err2},       32'd1);
    chk("nomul_data", {24'd0, out_data2},  32'd0);
    chk("nomul_hi",   {24'd0, out_hi2},    32'd0);

    // reset in the middle of a multiply
    do_op(4'd15, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mrst_vld",   {31'd0, out_valid},  32'd0);
    chk("mrst_rdy",   {31'd0, in_ready},   32'd0);
    chk("mrst_data",  {24'd0, out_data},   32'd0);
    chk("mrst_hi",    {24'd0, out_hi},     32'd0);
    chk("mrst_carry", {31'd0, carry_flag}, 32'd0);
    sbq.delete();
    mc = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk("mrst_rdy_rel", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_stale", seen, 32'd0);

    // random traffic with a randomly stalling consumer
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational 8-bit ALU in the IL processor execute stage.
- Width is generic. Operation is selected by a 4-bit opcode.
- Adds a persistent carry flag, carry-chained ADDC/SUBB, shifts, and an iterative multi-cycle MUL.
- Uses a valid/ready handshake on both input and output, so the pipeline controller can stall on MUL or on a blocked consumer.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 4..32).
- MUL_EN, 1, when 0 the MUL opcode is treated as unknown.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation this cycle
- opcode  input  4  operation select (encoding below)
- op1  input  WIDTH  operand 1
- op2  input  WIDTH  operand 2
- out_valid  output  1  result held in output register
- out_ready  input  1  consumer takes the result this cycle
- out_data  output  WIDTH  result (low half for MUL)
- out_hi  output  WIDTH  MUL high half; 0 for all other ops
- carry_flag  output  1  persistent carry/borrow flag
- zero_flag  output  1  out_data == 0, valid while out_valid
- err  output  1  current result came from an unknown opcode
- flag_clr  input  1  synchronous clear of carry_flag

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; FSM to IDLE; in_ready=0 while reset is asserted, 1 on the first cycle after release.
- Opcode encoding:
  - 0 AND, 1 OR, 2 XOR, 3 GT, 4 GE, 5 EQ, 6 LE, 7 LT
  - 8 ADD, 9 SUB, 10 LD (out=op1), 11 ADDC, 12 SUBB, 13 SHL, 14 SHR, 15 MUL
- Arithmetic and width rules:
  - Compares are unsigned; result is 1 or 0 in bit 0, upper bits zero.
  - ADD/ADDC: compute {1'b0,op1}+{1'b0,op2}(+carry_flag for ADDC) to WIDTH+1 bits; out=low WIDTH bits; carry=bit WIDTH.
  - SUB/SUBB: compute {1'b0,op1}-{1'b0,op2}(-carry_flag for SUBB); carry=bit WIDTH (borrow).
  - SHL: out=op1<<1, carry=op1[WIDTH-1]. SHR: logical, out=op1>>1, carry=op1[0].
  - MUL: unsigned; {out_hi,out_data}=op1*op2; carry=|out_hi.
  - Logic, compare and LD leave carry_flag unchanged.
  - Unknown opcode: out_data=0, err=1, carry unchanged.
- Handshake:
  - Accept when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A result is consumed when out_valid && out_ready, which clears out_valid unless a new result loads in the same cycle.
  - Outputs hold stable while out_valid && !out_ready.
- Latency:
  - Single-cycle ops: result registered on the accepting edge; out_valid=1 the next cycle. Back-to-back throughput is 1 per cycle while out_ready=1.
  - MUL: FSM IDLE -> MULT on accept. Radix-2 shift-add over WIDTH cycles (counter 0..WIDTH-1). On the final iteration the result loads into the output register, out_valid=1, and state returns to IDLE.
  - MUL accept-to-out_valid is WIDTH+1 cycles. in_ready=0 throughout MULT.
- Flag timing:
  - carry_flag updates on the same edge the result loads into the output register.
  - ADDC/SUBB use the carry_flag value at the accepting edge, which includes any update from the immediately preceding op.
  - flag_clr=1 clears carry_flag on the next edge.
  - If flag_clr and a carry-writing result load occur on the same edge, the result load wins.
- Boundary conditions:
  - Reset mid-MUL aborts the operation; no result is produced.
  - in_valid while in_ready=0 is ignored; the producer must hold it.
  - MUL_EN=0: opcode 15 is treated as unknown (single cycle, err=1).
  - WIDTH+1-bit intermediates must not truncate the carry.

Test Plan:
- WIDTH=8: ADD 0xF0+0x20 -> out_data=0x10, carry_flag=1 next cycle; then ADDC 0x01+0x01 -> 0x03, carry_flag=0.
- SUB 0x05-0x06 -> out_data=0xFF, carry_flag=1; then SUBB 0x10-0x00 -> 0x0F; compares GT/GE/EQ/LE/LT with 7 vs 7 -> 0,1,1,1,0.
- MUL 0xFF*0xFF -> out_valid exactly 9 cycles after accept, out_data=0x01, out_hi=0xFE, carry_flag=1, in_ready=0 during MULT.
- Back-to-back AND 0xF0&0x3C -> 0x30 and XOR 0xAA^0xFF -> 0x55 with out_ready=1: two consecutive out_valid cycles. Then hold out_ready=0: in_ready=0, out_data stays stable, zero_flag correct.
- Assert reset during MULT cycle 4 -> all outputs 0 immediately; after release, in_ready=1 and no stale result appears.
- flag_clr on the same edge as an ADD with carry -> carry_flag=1. flag_clr alone -> carry_flag=0. With MUL_EN=0, opcode 15 -> err=1, out_data=0.
